// File: rtl/tt_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: word length default,
// state encoding and a small helper.
package tt_serial_pkg;

    // Default maximum operand word length in bits.
    localparam int DEFAULT_WIDTH = 8;

    // Word framing states; the encoding is visible on uo_out[7:6].
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Smaller of two integers, used to size the result view on uio_out.
    function automatic int min_int(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

endpackage

// File: rtl/tt_um_serial_sub_fs_cell.sv
// One-bit full-subtractor cell (module fs_cell).
// Optional feature macro: SERIAL_SUB_ADD_MODE_EN. When it is defined, mode_i=1
// turns the cell into a full adder and borrow_o carries the carry-out.
// Without the macro the cell is a subtractor only and mode_i is ignored.
module fs_cell
    import tt_serial_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic borrow_i,
    input  logic mode_i,
    output logic d_o,
    output logic borrow_o
);

`ifdef SERIAL_SUB_ADD_MODE_EN
    // Difference/sum bit and borrow/carry out, selected by mode_i.
    always_comb begin
        d_o = a_i ^ b_i ^ borrow_i;
        if (mode_i) begin
            borrow_o = (a_i & b_i) | ((a_i ^ b_i) & borrow_i);
        end else begin
            borrow_o = (~a_i & b_i) | (~(a_i ^ b_i) & borrow_i);
        end
    end
`else
    // Subtraction only; mode_i has no effect in this build.
    logic unused_mode;
    assign unused_mode = mode_i;
    assign d_o         = a_i ^ b_i ^ borrow_i;
    assign borrow_o    = (~a_i & b_i) | (~(a_i ^ b_i) & borrow_i);
`endif

endmodule

// File: rtl/tt_um_serial_sub.sv
// Bit-serial subtractor, LSB first, one operand bit pair per accepted cycle.
// Optional feature macro: SERIAL_SUB_ADD_MODE_EN (ui_in[5]=1 latched on
// in_first selects addition). Without it ui_in[5] is ignored.
//
// Handshake: a bit is accepted on a rising clock edge where in_valid=1; there
// is no backpressure. An accepted bit takes part in a word only if it carries
// in_first or the block is in RUN; other accepted bits are dropped silently.
// Every bit that takes part produces exactly one out_valid pulse one cycle
// later, with d, borrow and out_last registered alongside it.
module tt_um_serial_sub
    import tt_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int OW = min_int(WIDTH, 8);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    logic a_bit, b_bit, in_valid, in_first, in_last;
    assign a_bit    = ui_in[0];
    assign b_bit    = ui_in[1];
    assign in_valid = ui_in[2];
    assign in_first = ui_in[3];
    assign in_last  = ui_in[4];

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:5]};

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             br_q, br_d;
    logic             d_q, d_d;
    logic             ov_q, ov_d;
    logic             ol_q, ol_d;
    logic             rv_q, rv_d;
    logic             len_err_q, len_err_d;

    logic live;
    logic cell_mode, cell_br_in, cell_d, cell_br_out;

    // A bit joins a word when it starts one or continues a running one.
    assign live       = in_valid & (in_first | (state_q == ST_RUN));
    // The first bit of a word starts with no borrow/carry pending.
    assign cell_br_in = in_first ? 1'b0 : br_q;

`ifdef SERIAL_SUB_ADD_MODE_EN
    logic mode_q;

    // Operation mode is captured with the first bit and held for the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
        end else if (live && in_first) begin
            mode_q <= ui_in[5];
        end
    end

    assign cell_mode = in_first ? ui_in[5] : mode_q;
`else
    assign cell_mode = 1'b0;
`endif

    fs_cell u_cell (
        .a_i      (a_bit),
        .b_i      (b_bit),
        .borrow_i (cell_br_in),
        .mode_i   (cell_mode),
        .d_o      (cell_d),
        .borrow_o (cell_br_out)
    );

    // Next-state: framing FSM, bit placement, status flags and output stream.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        br_d      = br_q;
        d_d       = d_q;
        ov_d      = 1'b0;
        ol_d      = 1'b0;
        rv_d      = rv_q;
        len_err_d = len_err_q;
        if (live) begin
            ov_d = 1'b1;
            ol_d = in_last;
            d_d  = cell_d;
            br_d = cell_br_out;
            if (in_first) begin
                // Start (or restart) a word; any word in progress is dropped.
                result_d    = '0;
                result_d[0] = cell_d;
                cnt_d       = CW'(1);
                len_err_d   = 1'b0;
                rv_d        = 1'b0;
                state_d     = ST_RUN;
            end else if (cnt_q < CW'(WIDTH)) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (cnt_q == CW'(i)) begin
                        result_d[i] = cell_d;
                    end
                end
                cnt_d = cnt_q + CW'(1);
            end else begin
                // Word longer than WIDTH: keep the low bits, flag the overrun.
                len_err_d = 1'b1;
            end
            if (in_last) begin
                state_d = ST_DONE;
                rv_d    = 1'b1;
            end
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            result_q  <= '0;
            br_q      <= 1'b0;
            d_q       <= 1'b0;
            ov_q      <= 1'b0;
            ol_q      <= 1'b0;
            rv_q      <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            br_q      <= br_d;
            d_q       <= d_d;
            ov_q      <= ov_d;
            ol_q      <= ol_d;
            rv_q      <= rv_d;
            len_err_q <= len_err_d;
        end
    end

    assign uo_out  = {state_q, len_err_q, rv_q, ol_q, ov_q, br_q, d_q};
    assign uio_out = 8'(result_q[OW-1:0]);
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_serial_sub.sv
// Self-checking bench for tt_um_serial_sub: a word-level arithmetic model
// predicts every output each cycle; directed words pin literal results.
module tb_tt_um_serial_sub;

    localparam int W = 8;
`ifdef SERIAL_SUB_ADD_MODE_EN
    localparam bit ADD_EN = 1'b1;
`else
    localparam bit ADD_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ena    = 1'b1;
    logic [7:0] ui_in  = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    always #5 clk = ~clk;

    tt_um_serial_sub #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int ov_cnt   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Words are accumulated as integers; each output bit is read off the
    // plain difference (or sum) of the operand prefixes seen so far.
    logic [7:0]      exp_q[$];
    longint unsigned a_acc, b_acc, s;
    int              k;
    int              m_state;
    bit              m_ov, m_rv, m_len, m_br, m_add;
    logic [7:0]      m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_ov = 0; m_rv = 0; m_len = 0; m_br = 0; m_add = 0;
            m_res = 8'h00; a_acc = 0; b_acc = 0; k = 0;
            exp_q.delete();
        end else begin
            bit v, f, l, live, dbit, brbit;
            int nb;
            v = ui_in[2]; f = ui_in[3]; l = ui_in[4];
            m_ov = 0;
            live = v && (f || m_state == 1);
            if (live) begin
                if (f) begin
                    a_acc = 0; b_acc = 0; k = 0; m_len = 0; m_rv = 0;
                    m_add = ADD_EN && ui_in[5];
                end
                a_acc = a_acc | (64'(ui_in[0]) << k);
                b_acc = b_acc | (64'(ui_in[1]) << k);
                s = m_add ? a_acc + b_acc : a_acc - b_acc;
                dbit  = s[k];
                brbit = m_add ? s[k+1] : (a_acc < b_acc);
                if (k >= W) m_len = 1;
                k++;
                m_ov = 1;
                m_br = brbit;
                exp_q.push_back({5'b0, l, brbit, dbit});
                if (l) begin
                    m_state = 2;
                    m_rv = 1;
                    nb = (k < W) ? k : W;
                    m_res = 8'(s & ((64'd1 << nb) - 1));
                end else if (f) begin
                    m_state = 1;
                end
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    logic [7:0] e;
    always @(negedge clk) begin
        if (uo_out[2]) ov_cnt++;
        if (rst_n) begin
            check("out_valid", uo_out[2], m_ov);
            check("state", uo_out[7:6], m_state[1:0]);
            check("result_valid", uo_out[4], m_rv);
            check("len_err", uo_out[5], m_len);
            check("uio_oe", uio_oe, 8'hFF);
            if (uo_out[2]) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stray_out_valid: got pulse expected none at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("d_bit", uo_out[0], e[0]);
                    check("bit_borrow", uo_out[1], e[1]);
                    check("out_last", uo_out[3], e[2]);
                end
            end
            if (m_rv) begin
                check("result_word", uio_out, m_res);
                check("final_borrow", uo_out[1], m_br);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit v, input bit a, input bit b, input bit f, input bit l, input bit md);
        ui_in = {2'($urandom), md, l, f, v, b, a};
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input longint unsigned a, input longint unsigned b, input int n,
                             input bit md, input int max_gap, input bit with_last);
        for (int i = 0; i < n; i++) begin
            int g;
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (g) drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), md);
            drive(1'b1, a[i], b[i], i == 0, with_last && (i == n - 1), md);
        end
        ui_in = 8'h00;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_uo_out", uo_out, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 5 - 3, back to back.
        send_word(64'h05, 64'h03, 8, 1'b0, 0, 1'b1);
        @(negedge clk);
        check("sub_5_3_word", uio_out, 8'h02);
        check("sub_5_3_borrow", uo_out[1], 1'b0);
        check("sub_5_3_rv", uo_out[4], 1'b1);
        @(posedge clk); #1;

        // 3 - 5 with random gaps; exactly 8 bit pulses.
        ov_cnt = 0;
        send_word(64'h03, 64'h05, 8, 1'b0, 3, 1'b1);
        @(negedge clk);
        check("sub_3_5_word", uio_out, 8'hFE);
        check("sub_3_5_borrow", uo_out[1], 1'b1);
        @(posedge clk); #1;
        check("sub_3_5_pulses", ov_cnt, 8);

        // 10-bit word overruns WIDTH.
        send_word(64'h3FF, 64'h001, 10, 1'b0, 0, 1'b1);
        @(negedge clk);
        check("long_word", uio_out, 8'hFE);
        check("long_len_err", uo_out[5], 1'b1);
        check("long_borrow", uo_out[1], 1'b0);
        @(posedge clk); #1;

        // Reset after the 4th bit of a word.
        send_word(64'hA5, 64'h3C, 4, 1'b0, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_uo_out", uo_out, 8'h00);
        check("midreset_uio_out", uio_out, 8'h00);
        check("midreset_state", uo_out[7:6], 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_word(64'h10, 64'h01, 8, 1'b0, 0, 1'b1);
        @(negedge clk);
        check("after_reset_word", uio_out, 8'h0F);
        check("after_reset_borrow", uo_out[1], 1'b0);
        @(posedge clk); #1;

        // Mode bit: addition only in the macro build.
        send_word(64'hFF, 64'h01, 8, 1'b1, 0, 1'b1);
        @(negedge clk);
        check("mode_word", uio_out, ADD_EN ? 8'h00 : 8'hFE);
        check("mode_flag", uo_out[1], ADD_EN ? 1'b1 : 1'b0);
        @(posedge clk); #1;

        // One-bit word: 0 - 1.
        send_word(64'h0, 64'h1, 1, 1'b0, 0, 1'b1);
        @(negedge clk);
        check("one_bit_word", uio_out, 8'h01);
        check("one_bit_borrow", uo_out[1], 1'b1);
        @(posedge clk); #1;

        // Abandoned word followed by a restart: 10 - 4 over 4 bits.
        send_word(64'h7, 64'h2, 3, 1'b0, 0, 1'b0);
        send_word(64'h0A, 64'h04, 4, 1'b0, 0, 1'b1);
        @(negedge clk);
        check("restart_word", uio_out, 8'h06);
        check("restart_borrow", uo_out[1], 1'b0);
        @(posedge clk); #1;

        // Random words, stray bits, abandons and gaps against the model.
        for (int it = 0; it < 200; it++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 2) begin
                drive(1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'($urandom));
                ui_in = 8'h00;
            end else begin
                send_word({$urandom, $urandom}, {$urandom, $urandom},
                          int'($urandom_range(1, 12)), 1'($urandom),
                          int'($urandom_range(0, 2)), sel != 2);
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) begin
            @(posedge clk); #1;
        end
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tt_um_serial_sub.md
TT_UM_SERIAL_SUB -- requirements
Module: tt_um_serial_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the maximum operand word length in bits.
REQ-002 SHALL have port clk  input  1  the single clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ena  input  1  power-good; ignored.
REQ-005 SHALL have port ui_in  input  8  [0]=a bit, [1]=b bit, [2]=in_valid, [3]=in_first, [4]=in_last, [5]=mode (add=1; used only with the macro), [7:6] unused.
REQ-006 SHALL have port uio_in  input  8  unused.
REQ-007 SHALL have port uo_out  output  8  [0]=d bit, [1]=borrow/carry, [2]=out_valid, [3]=out_last, [4]=result_valid, [5]=len_err, [7:6]=state code.
REQ-008 SHALL have port uio_out  output  8  assembled result word.
REQ-009 SHALL have port uio_oe  output  8  constant 8'hFF.

Function
REQ-010 SHALL be a bit-serial subtractor: one LSB-first operand bit pair per cycle with in_valid=1; cycles with in_valid=0 SHALL leave all state unchanged.
REQ-011 Per accepted bit: d = a ^ b ^ br; br_next = (~a & b) | (~(a ^ b) & br); br is treated as 0 when in_first=1.
REQ-012 d, br_next, out_valid and out_last (=in_last) SHALL be registered; latency exactly 1 cycle; out_valid high for exactly one cycle per accepted bit.
REQ-013 State machine IDLE(00) -> RUN(01) on an accepted bit with in_first=1; RUN -> DONE(10) on an accepted bit with in_last=1; DONE -> RUN on in_first; in_first and in_last together = 1-bit word, going IDLE/DONE -> DONE directly.
REQ-014 Accepted bits without in_first while in IDLE SHALL be ignored.
REQ-015 A bit counter SHALL place d at result position cnt (cleared on in_first); it SHALL saturate at WIDTH, extra bits not stored, and len_err set.
REQ-016 On entry to DONE, uio_out SHALL hold the assembled word (unwritten high bits 0), uo_out[1] the final borrow, and result_valid=1; all held until the next in_first.
REQ-017 in_first received in RUN SHALL abandon the current word and restart, with no result_valid pulse.
REQ-018 len_err SHALL clear on the next in_first.

Reset
REQ-019 Asserting rst_n=0 SHALL immediately force IDLE, clear cnt, br, result, and set every uo_out and uio_out bit to 0, including mid-word.
REQ-020 uio_oe SHALL be 8'hFF in and out of reset.

Configuration
REQ-021 Macro SERIAL_SUB_ADD_MODE_EN defined: mode (latched on in_first) =1 selects addition, d = a ^ b ^ c, c_next = (a & b) | ((a ^ b) & c), uo_out[1] = carry.
REQ-022 Macro undefined: ui_in[5] SHALL be ignored, subtraction only, no add logic present.

Structure
REQ-023 Shared package tt_serial_pkg SHALL hold the state enum (IDLE, RUN, DONE) and DEFAULT_WIDTH=8.
REQ-024 One combinational sub-module fs_cell (a, b, borrow_in, mode -> d, borrow_out) SHALL implement the bit cell.

Verification
REQ-025 A=0x05, B=0x03, 8 bits back-to-back -> uio_out=0x02, borrow=0, result_valid one cycle after last bit.
REQ-026 A=0x03, B=0x05, 8 bits with random in_valid gaps -> uio_out=0xFE, borrow=1, exactly 8 out_valid pulses.
REQ-027 10-bit word A=0x3FF, B=0x001 -> uio_out=0xFE, len_err=1, borrow=0.
REQ-028 rst_n low after 4th bit of a word -> all outputs 0, state IDLE; fresh word 0x10-0x01 -> 0x0F.
REQ-029 With SERIAL_SUB_ADD_MODE_EN, mode=1, A=0xFF, B=0x01 -> uio_out=0x00, carry=1; without macro same stimulus -> 0xFE, borrow=0.
